// File: rtl/sap_microsequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : sap_microsequencer_if
//  Description : Bundle between the instruction register / run-step controls
//                and the SAP microsequencer.
//                  run        - free-run enable
//                  step       - single-step request (one T-state per high)
//                  opcode     - opcode from the instruction register
//                  ctrl_word  - {Cp,Ep,Lm,Ce,Li,Ei,La,Ea,Su,Eu,Lb,Lo}
//                  t_state    - one-hot T-state issued this cycle
//                  instr_done - last T-state of an instruction issued
//                  halted     - sticky, set by HLT
//                  illegal    - sticky, set by an undefined opcode
//                master drives run/step/opcode; slave is the sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface sap_microsequencer_if #(
    parameter int NUM_T    = 6,
    parameter int OPCODE_W = 4
);
    logic                run;
    logic                step;
    logic [OPCODE_W-1:0] opcode;
    logic [11:0]         ctrl_word;
    logic [NUM_T-1:0]    t_state;
    logic                instr_done;
    logic                halted;
    logic                illegal;

    modport master (
        output run, step, opcode,
        input  ctrl_word, t_state, instr_done, halted, illegal
    );

    modport slave (
        input  run, step, opcode,
        output ctrl_word, t_state, instr_done, halted, illegal
    );
endinterface
`default_nettype wire

// File: rtl/sap_microsequencer.sv
`default_nettype none
// ============================================================================
//  Module      : sap_microsequencer
//  Description : SAP-class control sequencer. A one-hot ring of NUM_T
//                T-states (legal range 6..16) drives an opcode-decoded
//                microcode table. All state moves on the falling edge of clk
//                so the datapath can act on the control word at the
//                following rising edge.
//  Ports       : clk    - system clock (sequencer acts on the falling edge)
//                reset  - asynchronous, active-high
//                bus    - sap_microsequencer_if.slave (run, step, opcode in;
//                         ctrl_word, t_state, instr_done, halted, illegal out)
//  Parameters  : NUM_T     - ring length; states above T6 issue zero
//                OPCODE_W  - opcode width; bits above 3 must be zero
//                EARLY_END - 1: return to T1 after the last active state
//                            0: always walk all NUM_T states
//  Revision    : 1.0 - initial release
// ============================================================================
module sap_microsequencer #(
    parameter int NUM_T     = 6,
    parameter int OPCODE_W  = 4,
    parameter int EARLY_END = 1
) (
    input  wire logic            clk,
    input  wire logic            reset,
    sap_microsequencer_if.slave  bus
);

    // Control word bit positions, MSB..LSB = Cp,Ep,Lm,Ce,Li,Ei,La,Ea,Su,Eu,Lb,Lo
    localparam logic [11:0] c_CP = 12'h800;
    localparam logic [11:0] c_EP = 12'h400;
    localparam logic [11:0] c_LM = 12'h200;
    localparam logic [11:0] c_CE = 12'h100;
    localparam logic [11:0] c_LI = 12'h080;
    localparam logic [11:0] c_EI = 12'h040;
    localparam logic [11:0] c_LA = 12'h020;
    localparam logic [11:0] c_EA = 12'h010;
    localparam logic [11:0] c_SU = 12'h008;
    localparam logic [11:0] c_EU = 12'h004;
    localparam logic [11:0] c_LB = 12'h002;
    localparam logic [11:0] c_LO = 12'h001;

    localparam logic [NUM_T-1:0] c_T1 = {{(NUM_T-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_ACTIVE = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    typedef enum logic [2:0] {
        OC_NOP = 3'd0,
        OC_LDA = 3'd1,
        OC_ADD = 3'd2,
        OC_SUB = 3'd3,
        OC_OUT = 3'd4,
        OC_HLT = 3'd5,
        OC_ILL = 3'd6
    } op_class_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [NUM_T-1:0]    r_ring;
    logic [NUM_T-1:0]    w_ring_nxt;
    logic [OPCODE_W-1:0] r_op_held;
    logic [OPCODE_W-1:0] w_op;
    op_class_t           w_class;
    logic                w_upper_bad;
    logic                w_go;
    logic                w_is_t4;
    logic                w_last;
    logic                w_capture;
    logic                w_ill_set;
    logic                w_done_nxt;
    logic [11:0]         w_word;
    logic [11:0]         w_ctrl_nxt;
    logic [NUM_T-1:0]    w_tstate_nxt;

    logic [11:0]         r_ctrl;
    logic [NUM_T-1:0]    r_tstate;
    logic                r_done;
    logic                r_illegal;

    // Halted is folded into the FSM state, so only run/step matter here.
    assign w_go    = bus.run | bus.step;
    assign w_is_t4 = r_ring[3];

    // T4 decodes the live opcode; later states use the copy captured at T4
    // so an IR change mid-instruction cannot corrupt the execute phase.
    assign w_op = w_is_t4 ? bus.opcode : r_op_held;

    generate
        if (OPCODE_W > 4) begin : g_upper_bits
            assign w_upper_bad = |w_op[OPCODE_W-1:4];
        end else begin : g_no_upper_bits
            assign w_upper_bad = 1'b0;
        end
    endgenerate

    always_comb begin
        w_class = OC_ILL;
        if (!w_upper_bad) begin
            case (w_op[3:0])
                4'h0:    w_class = OC_NOP;
                4'h1:    w_class = OC_LDA;
                4'h2:    w_class = OC_ADD;
                4'h3:    w_class = OC_SUB;
                4'hE:    w_class = OC_OUT;
                4'hF:    w_class = OC_HLT;
                default: w_class = OC_ILL;
            endcase
        end
    end

    // Microcode table; anything past T6 falls through to zero.
    always_comb begin
        w_word = '0;
        if (r_ring[0]) begin
            w_word = c_EP | c_LM;
        end else if (r_ring[1]) begin
            w_word = c_CP;
        end else if (r_ring[2]) begin
            w_word = c_CE | c_LI;
        end else if (r_ring[3]) begin
            case (w_class)
                OC_LDA, OC_ADD, OC_SUB: w_word = c_EI | c_LM;
                OC_OUT:                 w_word = c_EA | c_LO;
                default:                w_word = '0;
            endcase
        end else if (r_ring[4]) begin
            case (w_class)
                OC_LDA:         w_word = c_CE | c_LA;
                OC_ADD, OC_SUB: w_word = c_CE | c_LB;
                default:        w_word = '0;
            endcase
        end else if (r_ring[5]) begin
            case (w_class)
                OC_ADD:  w_word = c_EU | c_LA;
                OC_SUB:  w_word = c_SU | c_EU | c_LA;
                default: w_word = '0;
            endcase
        end
    end

    // Last state of the current instruction: its final active state with
    // early return, otherwise the top of the ring.
    always_comb begin
        w_last = r_ring[NUM_T-1];
        if (EARLY_END != 0) begin
            case (w_class)
                OC_LDA:         w_last = r_ring[4];
                OC_ADD, OC_SUB: w_last = r_ring[5];
                default:        w_last = r_ring[3];
            endcase
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_ring_nxt   = r_ring;
        w_ctrl_nxt   = '0;
        w_tstate_nxt = '0;
        w_done_nxt   = 1'b0;
        w_ill_set    = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            ST_ACTIVE: begin
                if (w_go) begin
                    w_tstate_nxt = r_ring;
                    w_capture    = w_is_t4;
                    if (w_is_t4 && (w_class == OC_HLT)) begin
                        // HLT issues a zero word and freezes the ring at T4.
                        w_state_nxt = ST_HALTED;
                    end else begin
                        w_ctrl_nxt = w_word;
                        w_done_nxt = w_last;
                        w_ill_set  = w_is_t4 && (w_class == OC_ILL);
                        w_ring_nxt = w_last ? c_T1 : {r_ring[NUM_T-2:0], 1'b0};
                    end
                end
            end
            ST_HALTED: begin
                w_state_nxt = ST_HALTED;
            end
            default: begin
                w_state_nxt = ST_ACTIVE;
            end
        endcase
    end

    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_ACTIVE;
            r_ring  <= c_T1;
        end else begin
            r_state <= w_state_nxt;
            r_ring  <= w_ring_nxt;
        end
    end

    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            r_ctrl    <= '0;
            r_tstate  <= '0;
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
            r_op_held <= '0;
        end else begin
            r_ctrl    <= w_ctrl_nxt;
            r_tstate  <= w_tstate_nxt;
            r_done    <= w_done_nxt;
            r_illegal <= r_illegal | w_ill_set;
            if (w_capture) begin
                r_op_held <= bus.opcode;
            end
        end
    end

    assign bus.ctrl_word  = r_ctrl;
    assign bus.t_state    = r_tstate;
    assign bus.instr_done = r_done;
    assign bus.halted     = (r_state == ST_HALTED);
    assign bus.illegal    = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_sap_microsequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sap_microsequencer
//  Description : Self-checking bench. Two sequencers share stimulus:
//                  a: NUM_T=6, EARLY_END=1
//                  b: NUM_T=8, EARLY_END=0
//                A T-number/opcode reference model predicts every output.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sap_microsequencer;

    localparam logic [11:0] CP = 12'h800, EP = 12'h400, LM = 12'h200, CE = 12'h100;
    localparam logic [11:0] LI = 12'h080, EI = 12'h040, LA = 12'h020, EA = 12'h010;
    localparam logic [11:0] SU = 12'h008, EU = 12'h004, LB = 12'h002, LO = 12'h001;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    sap_microsequencer_if #(.NUM_T(6), .OPCODE_W(4)) bus_a ();
    sap_microsequencer_if #(.NUM_T(8), .OPCODE_W(4)) bus_b ();

    sap_microsequencer #(.NUM_T(6), .OPCODE_W(4), .EARLY_END(1)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a.slave)
    );

    sap_microsequencer #(.NUM_T(8), .OPCODE_W(4), .EARLY_END(0)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b.slave)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state, index 0 = instance a, 1 = instance b
    int          m_ptr  [2];
    logic [3:0]  m_held [2];
    bit          m_halt [2];
    bit          m_ill  [2];
    logic [11:0] e_word [2];
    logic [15:0] e_t    [2];
    bit          e_done [2];

    function automatic logic [11:0] word_of(int t, logic [3:0] op);
        case (t)
            1: return EP | LM;
            2: return CP;
            3: return CE | LI;
            4: begin
                if (op == 4'h1 || op == 4'h2 || op == 4'h3) return EI | LM;
                if (op == 4'hE) return EA | LO;
                return 12'h000;
            end
            5: begin
                if (op == 4'h1) return CE | LA;
                if (op == 4'h2 || op == 4'h3) return CE | LB;
                return 12'h000;
            end
            6: begin
                if (op == 4'h2) return EU | LA;
                if (op == 4'h3) return SU | EU | LA;
                return 12'h000;
            end
            default: return 12'h000;
        endcase
    endfunction

    function automatic int last_of(logic [3:0] op);
        if (op == 4'h1) return 5;
        if (op == 4'h2 || op == 4'h3) return 6;
        return 4;
    endfunction

    function automatic bit known(logic [3:0] op);
        return (op == 4'h0 || op == 4'h1 || op == 4'h2 || op == 4'h3 ||
                op == 4'hE || op == 4'hF);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_ptr[k]  = 1;
            m_held[k] = 4'h0;
            m_halt[k] = 1'b0;
            m_ill[k]  = 1'b0;
            e_word[k] = 12'h000;
            e_t[k]    = 16'h0000;
            e_done[k] = 1'b0;
        end
    endtask

    // Predict what the coming falling edge does for instance k.
    task automatic model_step(int k);
        bit         go;
        int         t;
        int         last;
        logic [3:0] op;
        go        = (bus_a.run || bus_a.step) && !m_halt[k];
        e_word[k] = 12'h000;
        e_t[k]    = 16'h0000;
        e_done[k] = 1'b0;
        if (go) begin
            t = m_ptr[k];
            op = (t == 4) ? bus_a.opcode : m_held[k];
            if (t == 4) m_held[k] = bus_a.opcode;
            e_t[k] = 16'h0001 << (t - 1);
            if (t == 4 && op == 4'hF) begin
                m_halt[k] = 1'b1;
            end else begin
                e_word[k] = word_of(t, op);
                if (t == 4 && !known(op)) m_ill[k] = 1'b1;
                last      = (k == 0) ? last_of(op) : 8;
                e_done[k] = (t == last);
                m_ptr[k]  = (t == last) ? 1 : t + 1;
            end
        end
    endtask

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("check %s differs", tag);
        end
    endtask

    task automatic check_all(string tag);
        check({tag, " a.ctrl_word"},  32'(bus_a.ctrl_word),  32'(e_word[0]));
        check({tag, " a.t_state"},    32'(bus_a.t_state),    32'(e_t[0]));
        check({tag, " a.instr_done"}, 32'(bus_a.instr_done), 32'(e_done[0]));
        check({tag, " a.halted"},     32'(bus_a.halted),     32'(m_halt[0]));
        check({tag, " a.illegal"},    32'(bus_a.illegal),    32'(m_ill[0]));
        check({tag, " b.ctrl_word"},  32'(bus_b.ctrl_word),  32'(e_word[1]));
        check({tag, " b.t_state"},    32'(bus_b.t_state),    32'(e_t[1]));
        check({tag, " b.instr_done"}, 32'(bus_b.instr_done), 32'(e_done[1]));
        check({tag, " b.halted"},     32'(bus_b.halted),     32'(m_halt[1]));
        check({tag, " b.illegal"},    32'(bus_b.illegal),    32'(m_ill[1]));
    endtask

    task automatic set_in(logic r, logic s, logic [3:0] op);
        bus_a.run = r;  bus_a.step = s;  bus_a.opcode = op;
        bus_b.run = r;  bus_b.step = s;  bus_b.opcode = op;
    endtask

    // One clock: model predicts the falling edge, outputs are checked
    // one time unit after the following rising edge.
    task automatic cycle(string tag);
        model_step(0);
        model_step(1);
        @(negedge clk);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    // Asynchronous pulse placed mid-cycle, well clear of the falling edge.
    task automatic async_reset(string tag);
        reset = 1'b1;
        #1;
        model_reset();
        check_all(tag);
        #1;
        reset = 1'b0;
    endtask

    task automatic run_cycles(int n, logic [3:0] op, string tag);
        set_in(1'b1, 1'b0, op);
        for (int i = 0; i < n; i++) cycle(tag);
    endtask

    initial begin
        set_in(1'b0, 1'b0, 4'h0);
        model_reset();
        #1;
        async_reset("reset");

        // LDA, then SUB, then OUT sequences
        run_cycles(7,  4'h1, "lda");
        run_cycles(14, 4'h3, "sub");
        run_cycles(16, 4'hE, "out");

        // Single-step pulses with idle gaps
        async_reset("reset2");
        for (int p = 0; p < 3; p++) begin
            set_in(1'b0, 1'b1, 4'h2);
            cycle("step");
            set_in(1'b0, 1'b0, 4'h2);
            cycle("step_gap");
            cycle("step_gap");
        end

        // Halt, stays quiet despite run, then reset restarts fetch
        async_reset("reset3");
        run_cycles(24, 4'hF, "hlt");
        #1;
        async_reset("hlt_reset");
        run_cycles(3, 4'h1, "after_hlt");

        // Illegal opcode, then normal instruction
        async_reset("reset4");
        run_cycles(10, 4'h7, "ill");
        run_cycles(8,  4'h2, "post_ill");

        // Opcode changes after T4 are ignored
        async_reset("reset5");
        run_cycles(4, 4'h2, "hold_t4");
        run_cycles(4, 4'h1, "hold_late");

        // Reset during T5 of an ADD
        async_reset("reset6");
        run_cycles(5, 4'h2, "add_to_t5");
        #1;
        async_reset("add_t5_reset");

        // Randomized run/step/opcode with occasional resets
        for (int i = 0; i < 400; i++) begin
            set_in(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                   4'($urandom_range(0, 15)));
            cycle("rand");
            if (((m_halt[0] || m_halt[1]) && $urandom_range(0, 7) == 0) ||
                $urandom_range(0, 99) == 0) begin
                #1;
                async_reset("rand_reset");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
